// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serial pattern sequencer with prescaled capture strobes and detector hit counting
module shift_seq_ctrl #(
  parameter int PAT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [4:0]       len,
  input  logic [7:0]       div,
  input  logic             det,
  output logic             x,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hit_cnt,
  output logic [4:0]       bit_idx
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [4:0]       len_q, len_d;
  logic [7:0]       div_q, div_d;
  logic [7:0]       presc_q, presc_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       hit_q, hit_d;
  logic             samp_q, samp_d;
  logic [4:0]       idx_inc;
  assign idx_inc  = idx_q + 5'd1;
  assign shift_en = (state_q == SHIFT) && (presc_q == 8'd0);
  assign x        = (state_q == SHIFT) && sh_q[PAT_W-1];
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign hit_cnt  = hit_q;
  assign bit_idx  = idx_q;
  // next-state: accept start in IDLE, pace strobes by the prescaler, count hits one cycle after each strobe
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    len_d   = len_q;
    div_d   = div_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    samp_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        sh_d    = pattern;
        len_d   = (len == 5'd0) ? 5'd16 : len;
        div_d   = div;
        presc_d = div;
        idx_d   = 5'd0;
        hit_d   = 4'd0;
        state_d = SHIFT;
      end
    end else if (abort) begin
      state_d = IDLE;
    end else begin
      if (samp_q && det && hit_q != 4'hf) hit_d = hit_q + 4'd1;
      if (state_q == SHIFT) begin
        if (shift_en) begin
          sh_d    = {sh_q[PAT_W-2:0], 1'b0};
          idx_d   = idx_inc;
          presc_d = div_q;
          samp_d  = 1'b1;
          state_d = (idx_inc == len_q) ? DRAIN : SHIFT;
        end else begin
          presc_d = presc_q - 8'd1;
        end
      end else begin
        state_d = (state_q == DRAIN) ? DONE : IDLE;
      end
    end
  end
  // state registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      len_q   <= '0;
      div_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      samp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      samp_q  <= samp_d;
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed checks of sequencing, strobes, hit counting, abort and reset
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic reset, start, abort, det, x, shift_en, busy, done;
  logic [15:0] pattern;
  logic [4:0] len, bit_idx;
  logic [7:0] div;
  logic [3:0] hit_cnt;
  int total = 0;
  int bad = 0;
  logic det_tie, det_m;
  logic [5:0] q;
  logic [31:0] se_m, dn_m, bz_m, xs;
  int xerr;

  shift_seq_ctrl #(.PAT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .div(div), .det(det), .x(x), .shift_en(shift_en), .busy(busy),
    .done(done), .hit_cnt(hit_cnt), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  assign det = det_tie | det_m;

  // downstream shift register with registered 6-bit sequence detector
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
      det_m <= 1'b0;
    end else if (start && !busy && !abort) begin
      q <= '0;
      det_m <= 1'b0;
    end else if (shift_en) begin
      q <= {q[4:0], x};
      det_m <= ({q[4:0], x} == 6'b010101) || ({q[4:0], x} == 6'b110101);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // start a sequence and record per-cycle strobe/done/busy masks and strobed x bits
  task automatic run(input logic [15:0] p, input logic [4:0] l, input logic [7:0] d,
                     input int n, input int ab_c, input int st2_c);
    logic xa;
    pattern = p; len = l; div = d; start = 1'b1; abort = 1'b0;
    se_m = '0; dn_m = '0; bz_m = '0; xs = '0; xerr = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      se_m[c] = shift_en;
      dn_m[c] = done;
      bz_m[c] = busy;
      start = (c == st2_c);
      abort = (c == ab_c);
      if (c == st2_c) begin
        pattern = 16'hFFFF; len = 5'd2; div = 8'd5;
      end
      if (shift_en) begin
        xs = {xs[30:0], x};
        xa = x;
        #7;
        if (x !== xa) xerr++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; len = '0; div = '0; det_tie = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {x, shift_en, busy, done}, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_idx", bit_idx, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("st_ab_idle", busy, 0);

    run(16'h5600, 5'd7, 8'd0, 12, 0, 0);
    chk("p7_se", se_m, 32'h0000_00FE);
    chk("p7_x", xs, 32'h2B);
    chk("p7_done", dn_m, 32'h0000_0200);
    chk("p7_busy", bz_m, 32'h0000_03FE);
    chk("p7_hit", hit_cnt, 1);
    chk("p7_idx", bit_idx, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_hit", hit_cnt, 1);
    chk("hold_idx", bit_idx, 7);

    run(16'h8000, 5'd2, 8'd3, 12, 0, 0);
    chk("d3_se", se_m, 32'h0000_0110);
    chk("d3_x", xs, 32'h2);
    chk("d3_done", dn_m, 32'h0000_0400);
    chk("d3_idx", bit_idx, 2);
    chk("d3_xstable", xerr, 0);
    chk("d3_hit", hit_cnt, 0);

    det_tie = 1'b1;
    run(16'hA5C3, 5'd0, 8'd0, 20, 0, 0);
    det_tie = 1'b0;
    chk("l16_se", se_m, 32'h0001_FFFE);
    chk("l16_x", xs, 32'hA5C3);
    chk("l16_hit", hit_cnt, 15);
    chk("l16_idx", bit_idx, 16);
    chk("l16_done", dn_m, 32'h0004_0000);

    run(16'hFFFF, 5'd8, 8'd1, 12, 7, 0);
    chk("ab_se", se_m, 32'h0000_0054);
    chk("ab_busy", bz_m, 32'h0000_00FE);
    chk("ab_done", dn_m, 32'h0);
    chk("ab_idx", bit_idx, 3);

    run(16'h5600, 5'd7, 8'd0, 12, 0, 3);
    chk("ign_se", se_m, 32'h0000_00FE);
    chk("ign_x", xs, 32'h2B);
    chk("ign_done", dn_m, 32'h0000_0200);
    chk("ign_hit", hit_cnt, 1);
    chk("ign_idx", bit_idx, 7);

    pattern = 16'hFFFF; len = 5'd8; div = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst", {x, shift_en, busy}, 3'b111);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_outs", {x, shift_en, busy, done}, 0);
    chk("mid_rst_cnt", {hit_cnt, bit_idx}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post_rst_busy", busy, 0);
    run(16'hC000, 5'd3, 8'd0, 8, 0, 0);
    chk("pr_se", se_m, 32'h0000_000E);
    chk("pr_x", xs, 32'h6);
    chk("pr_done", dn_m, 32'h0000_0020);
    chk("pr_idx", bit_idx, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
